// File: rtl/fma_normalize_round.sv
// fma_normalize_round: last FP32 FMA stage. S1 finds the leading one and aligns it. S2 rounds (RNE) and packs.
// Define FMA_FTZ_EN to flush results whose pre-round exponent is <= 0 to signed zero.
module fma_normalize_round #(
  parameter int SUM_W = 74,
  parameter int EXP_W = 10,
  parameter int POINT = 46
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             in_nan,
  input  logic             in_inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result
);
  localparam int EW = EXP_W + 1;
  localparam int PW = $clog2(SUM_W);
  localparam int FW = 23;

  typedef struct packed {
    logic          sign;
    logic          nan;
    logic          inf;
    logic          zero;
`ifdef FMA_FTZ_EN
    logic          tiny;
`endif
    logic [EW-1:0] exp;
    logic          hidden;
    logic [FW-1:0] frac;
    logic          guard;
    logic          sticky;
  } s1_t;

  // Handshake: a word moves on a rising edge where valid && ready. A producer keeps valid and data
  // steady until that edge. A stage loads when it is empty or when its current word leaves this cycle.
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  logic        s1_load, s2_load;
  s1_t         s1_q, s1_d, s1_new;
  logic [31:0] res_q, res_d, res_new;

  assign s2_load    = !s2_valid_q || out_ready;
  assign s1_load    = !s1_valid_q || s2_load;
  assign in_ready   = s1_load;
  assign out_valid  = s2_valid_q;
  assign out_result = res_q;

  logic [PW-1:0]    lead_pos;
  logic [SUM_W-1:0] norm_sum, aligned;
  logic [EW-1:0]    e_pre;
  logic             tiny, lost;
`ifndef FMA_FTZ_EN
  logic [EW-1:0]      sub_amt;
  logic [PW-1:0]      sub_sh;
  logic [2*SUM_W-1:0] sub_wide;
`endif

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (in_sum[i]) lead_pos = PW'(i);
    end
  end

  always_comb begin
    norm_sum = in_sum << (PW'(SUM_W - 1) - lead_pos);
    e_pre    = {in_exp[EXP_W-1], in_exp} + EW'(lead_pos) - EW'(POINT);
    tiny     = e_pre[EW-1] || (e_pre == '0);
`ifdef FMA_FTZ_EN
    aligned  = norm_sum;
    lost     = 1'b0;
`else
    // Tiny values slide right by 1-E. Bits pushed past the bottom are kept only as sticky.
    sub_amt  = EW'(1) - e_pre;
    sub_sh   = '0;
    if (tiny) sub_sh = (sub_amt > EW'(SUM_W)) ? PW'(SUM_W) : sub_amt[PW-1:0];
    sub_wide = {norm_sum, {SUM_W{1'b0}}} >> sub_sh;
    aligned  = sub_wide[2*SUM_W-1:SUM_W];
    lost     = |sub_wide[SUM_W-1:0];
`endif
    s1_new        = '0;
    s1_new.sign   = in_sign;
    s1_new.nan    = in_nan;
    s1_new.inf    = in_inf;
    s1_new.zero   = (in_sum == '0);
`ifdef FMA_FTZ_EN
    s1_new.tiny   = tiny;
`endif
    s1_new.exp    = tiny ? '0 : e_pre;
    s1_new.hidden = aligned[SUM_W-1];
    s1_new.frac   = aligned[SUM_W-2 -: FW];
    s1_new.guard  = aligned[SUM_W-2-FW];
    s1_new.sticky = (|aligned[SUM_W-3-FW:0]) || lost;

    s1_d       = s1_load ? s1_new : s1_q;
    s1_valid_d = s1_load ? in_valid : s1_valid_q;
  end

  logic          inc;
  logic [FW+1:0] mant;
  logic [EW-1:0] e_rnd;

  always_comb begin
    inc  = s1_q.guard && (s1_q.sticky || s1_q.frac[0]);
    mant = {1'b0, s1_q.hidden, s1_q.frac} + (FW+2)'(inc);
    // A subnormal that rounds into the hidden bit becomes the smallest normal.
    e_rnd = (s1_q.exp == '0) ? EW'(mant[FW]) : s1_q.exp + EW'(mant[FW+1]);

    if (s1_q.nan)                res_new = 32'h7FC0_0000;
    else if (s1_q.inf)           res_new = {s1_q.sign, 8'hFF, 23'h0};
    else if (s1_q.zero)          res_new = {s1_q.sign, 31'h0};
`ifdef FMA_FTZ_EN
    else if (s1_q.tiny)          res_new = {s1_q.sign, 31'h0};
`endif
    else if (e_rnd >= EW'(255))  res_new = {s1_q.sign, 8'hFF, 23'h0};
    else                         res_new = {s1_q.sign, e_rnd[7:0], mant[FW-1:0]};

    res_d      = s2_load ? res_new : res_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      res_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      res_q      <= res_d;
    end
  end
endmodule

// File: tb/tb_fma_normalize_round.sv
// Bench for fma_normalize_round. It runs directed cases first, then random traffic
// that is scored against an exact arithmetic model of the FP32 rounding.
module tb_fma_normalize_round;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sign, in_nan, in_inf;
  logic [9:0]  in_exp;
  logic [73:0] in_sum;
  logic        out_valid, out_ready;
  logic [31:0] out_result;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  localparam logic [73:0] ONE = 74'd1 << 46;
  localparam int N_RND = 400;

  fma_normalize_round dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_sum(in_sum),
    .in_nan(in_nan), .in_inf(in_inf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // The model works on the real value in_sum * 2^(in_exp-173). It picks the result quantum
  // (2^(max(E,1)-150)) and rounds the value to an integer count of quanta, ties to even.
  function automatic logic [31:0] ref_fp32(input logic sign, input logic [9:0] e_in,
                                           input logic [73:0] sum, input logic nan, input logic inf);
    int p, e, s, emax;
    logic [127:0] v, q, rem, half, m;
    logic [63:0] bits;
    if (nan) return 32'h7FC00000;
    if (inf) return {sign, 8'hFF, 23'h0};
    if (sum == '0) return {sign, 31'h0};
    p = 0;
    for (int i = 0; i < 74; i++) if (sum[i]) p = i;
    e = int'($signed(e_in)) + p - 46;
`ifdef FMA_FTZ_EN
    if (e <= 0) return {sign, 31'h0};
`endif
    emax = (e > 1) ? e : 1;
    s = emax - int'($signed(e_in)) + 23;
    v = 128'(sum);
    if (s <= 0) m = v << (-s);
    else if (s > 100) m = '0;
    else begin
      q = v >> s;
      rem = v - (q << s);
      half = 128'd1 << (s - 1);
      m = q;
      if (rem > half || (rem == half && q[0])) m = q + 128'd1;
    end
    bits = (64'(emax - 1) << 23) + m[63:0];
    if (bits >= 64'h7F800000) return {sign, 8'hFF, 23'h0};
    return {sign, bits[30:0]};
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sum = '0; in_nan = 1'b0; in_inf = 1'b0;
  endtask

  task automatic drive_in(input logic s, input logic [9:0] e, input logic [73:0] m,
                          input logic n, input logic f);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_sum = m; in_nan = n; in_inf = f;
  endtask

  task automatic gen_rand();
    logic [95:0] r;
    logic [73:0] m;
    int pos, cls, e_tgt;
    logic [9:0] ex;
    r = {$urandom, $urandom, $urandom};
    pos = int'($urandom_range(0, 73));
    m = (r[73:0] & ((74'd1 << pos) - 74'd1)) | (74'd1 << pos);
    if (pos >= 24 && $urandom_range(0, 3) == 0) begin
      m = m & ~((74'd1 << (pos - 24)) - 74'd1);
      m = m | (74'd1 << (pos - 24));
    end
    cls = int'($urandom_range(0, 3));
    case (cls)
      0:       e_tgt = int'($urandom_range(0, 32)) - 30;
      1:       e_tgt = int'($urandom_range(1, 254));
      2:       e_tgt = int'($urandom_range(245, 260));
      default: e_tgt = int'($urandom_range(0, 1023)) - 512 + pos - 46;
    endcase
    ex = 10'(e_tgt - pos + 46);
    if ($urandom_range(0, 7) == 0) m = '0;
    drive_in(1'($urandom_range(0, 1)), ex, m,
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
  endtask

  task automatic directed(input string tag, input logic s, input logic [9:0] e, input logic [73:0] m,
                          input logic n, input logic f, input logic [31:0] expv);
    @(negedge clk);
    drive_in(s, e, m, n, f);
    out_ready = 1'b1;
    #1 chk({tag, "_acc"}, in_ready, 1);
    @(negedge clk);
    drive_idle();
    #1 chk({tag, "_lat"}, out_valid, 0);
    @(negedge clk);
    #1 chk({tag, "_vld"}, out_valid, 1);
    chk(tag, out_result, expv);
    @(negedge clk);
    #1 chk({tag, "_drain"}, out_valid, 0);
  endtask

  initial begin
    logic pending, held_valid;
    logic [31:0] held_res;
    int n_sent, n_recv;

    rst = 1'b1;
    out_ready = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    directed("one", 1'b0, 10'd127, ONE, 1'b0, 1'b0, 32'h3F800000);
    directed("tie_even", 1'b0, 10'd127, ONE | (74'd1 << 22), 1'b0, 1'b0, 32'h3F800000);
    directed("tie_odd", 1'b0, 10'd127, ONE | (74'd1 << 23) | (74'd1 << 22), 1'b0, 1'b0, 32'h3F800002);
    directed("ovf_pos", 1'b0, 10'd254, ((74'd1 << 25) - 74'd1) << 22, 1'b0, 1'b0, 32'h7F800000);
    directed("ovf_neg", 1'b1, 10'd254, ((74'd1 << 25) - 74'd1) << 22, 1'b0, 1'b0, 32'hFF800000);
`ifdef FMA_FTZ_EN
    directed("subnorm", 1'b0, 10'd0, ONE, 1'b0, 1'b0, 32'h00000000);
`else
    directed("subnorm", 1'b0, 10'd0, ONE, 1'b0, 1'b0, 32'h00400000);
    directed("sub_round_up", 1'b0, 10'd0, ((74'd1 << 25) - 74'd1) << 22, 1'b0, 1'b0, 32'h00800000);
`endif
    directed("neg_zero", 1'b1, 10'd127, 74'd0, 1'b0, 1'b0, 32'h80000000);
    directed("nan", 1'b1, 10'd127, ONE, 1'b1, 1'b1, 32'h7FC00000);
    directed("neg_inf", 1'b1, 10'd127, ONE, 1'b0, 1'b1, 32'hFF800000);

    // Three words back to back while the consumer stalls for four cycles.
    @(negedge clk);
    out_ready = 1'b0;
    drive_in(1'b0, 10'd127, ONE, 1'b0, 1'b0);
    #1 chk("stall_acc1", in_ready, 1);
    @(negedge clk);
    drive_in(1'b0, 10'd127, ONE << 1, 1'b0, 1'b0);
    #1 chk("stall_acc2", in_ready, 1);
    @(negedge clk);
    drive_in(1'b0, 10'd127, 74'd3 << 46, 1'b0, 1'b0);
    #1 chk("stall_full", in_ready, 0);
    chk("stall_hold_a", out_result, 32'h3F800000);
    @(negedge clk);
    #1 chk("stall_full2", in_ready, 0);
    chk("stall_vld", out_valid, 1);
    chk("stall_hold_b", out_result, 32'h3F800000);
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("stall_out0", out_result, 32'h3F800000);
    chk("stall_rel_ready", in_ready, 1);
    @(negedge clk);
    drive_idle();
    #1 chk("stall_vld1", out_valid, 1);
    chk("stall_out1", out_result, 32'h40000000);
    @(negedge clk);
    #1 chk("stall_vld2", out_valid, 1);
    chk("stall_out2", out_result, 32'h40400000);
    @(negedge clk);
    #1 chk("stall_empty", out_valid, 0);

    // Reset with two words in flight.
    @(negedge clk);
    out_ready = 1'b0;
    drive_in(1'b0, 10'd127, ONE, 1'b0, 1'b0);
    @(negedge clk);
    drive_in(1'b0, 10'd127, ONE << 1, 1'b0, 1'b0);
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    #1 chk("mid_full", out_valid, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1 chk("mid_rst_vld", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("mid_no_stale", out_valid, 0);
    end

    // Random traffic with random gaps and back-pressure.
    pending = 1'b0;
    held_valid = 1'b0;
    held_res = '0;
    n_sent = 0;
    n_recv = 0;
    for (int cyc = 0; cyc < 8000 && n_recv < N_RND; cyc++) begin
      @(negedge clk);
      if (!pending) begin
        if (n_sent < N_RND && $urandom_range(0, 3) != 0) begin
          gen_rand();
          pending = 1'b1;
        end else begin
          drive_idle();
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (held_valid) begin
        chk("rnd_hold_vld", out_valid, 1);
        chk("rnd_hold_data", out_result, held_res);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_fp32(in_sign, in_exp, in_sum, in_nan, in_inf));
        pending = 1'b0;
        n_sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("rnd_spurious", out_valid, 0);
        else chk("rnd_data", out_result, exp_q.pop_front());
        n_recv++;
      end
      chk("rnd_occupancy", (exp_q.size() <= 2), 1);
      held_valid = out_valid && !out_ready;
      held_res = out_result;
    end
    chk("rnd_count", n_recv, N_RND);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
